// File: rtl/soc_system_mbox_pkg.sv
// Shared definitions for the ARM-to-Nios mailbox: register map, CONTROL/STATUS
// bit positions and the ARM handshake state encoding.
package soc_system_mbox_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;
  localparam logic [1:0] ADDR_RSVD    = 2'd3;

  localparam int CTRL_IRQ_EN    = 0;
  localparam int CTRL_FLUSH     = 1;
  localparam int CTRL_CLR_UF    = 2;

  localparam int STAT_UNDERFLOW = 7;
  localparam int STAT_COUNT_W   = 5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    WAIT_LOW = 2'd2
  } hs_state_e;

endpackage

// File: rtl/soc_system_mbox_fifo.sv
// Mailbox word FIFO: power-of-2 depth, head word visible combinationally,
// synchronous flush that overrides a same-cycle push or pop.
module soc_system_mbox_fifo #(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [31:0]   wdata,
  output logic [31:0]   head,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    // NOTE: every next-state value gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are exactly AW bits wide, so the increment wraps modulo DEPTH.
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count/pointers alone define which words are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/soc_system_arm2nios_mbox_ctrl.sv
// ARM-to-Nios mailbox: four-phase handshake from the ARM PIO pushes words into a
// FIFO that the Nios drains through a small Avalon-MM register slave.
module soc_system_arm2nios_mbox_ctrl
  import soc_system_mbox_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] arm_data,
  input  logic        arm_valid,
  output logic        arm_ack,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq
);

  localparam int CW = $clog2(DEPTH) + 1;

  hs_state_e     state_q, state_d;
  logic          arm_ack_q, arm_ack_d;
  logic          push;

  logic          rd_en, wr_en, ctrl_wr, data_rd;
  logic          pop, flush;
  logic          irq_en_q, irq_en_d;
  logic          underflow_q, underflow_d;
  logic          irq_q, irq_d;
  logic [31:0]   readdata_q, readdata_d;
  logic [31:0]   status_word, ctrl_word;

  logic [31:0]   head;
  logic [CW-1:0] fifo_count;
  logic          empty, full;
  logic          unused_wdata;

  soc_system_mbox_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wdata   (arm_data),
    .head    (head),
    .count   (fifo_count),
    .empty   (empty),
    .full    (full)
  );

  // A full FIFO holds the FSM in IDLE, which stalls the ARM with ack low.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (arm_valid && !full) begin
          push    = 1'b1;
          state_d = ACK;
        end
      end
      ACK:      state_d = WAIT_LOW;
      WAIT_LOW: if (!arm_valid) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    arm_ack_d = (state_d != IDLE);
  end

  assign rd_en        = chipselect & read;
  assign wr_en        = chipselect & ~write_n;
  assign ctrl_wr      = wr_en && (address == ADDR_CONTROL);
  assign data_rd      = rd_en && (address == ADDR_DATA);
  assign flush        = ctrl_wr & writedata[CTRL_FLUSH];
  assign pop          = data_rd & ~empty;
  assign unused_wdata = ^writedata[31:3];

  always_comb begin
    status_word                   = '0;
    status_word[STAT_UNDERFLOW]   = underflow_q;
    status_word[STAT_COUNT_W-1:0] = STAT_COUNT_W'(fifo_count);
    ctrl_word                     = '0;
    ctrl_word[CTRL_IRQ_EN]        = irq_en_q;
  end

  always_comb begin
    readdata_d  = readdata_q;
    irq_en_d    = irq_en_q;
    underflow_d = underflow_q;
    if (ctrl_wr) begin
      irq_en_d = writedata[CTRL_IRQ_EN];
      if (writedata[CTRL_CLR_UF]) underflow_d = 1'b0;
    end
    // A fresh underflow wins over a same-cycle clear so the event is never lost.
    if (data_rd && empty) underflow_d = 1'b1;
    if (rd_en) begin
      case (address)
        ADDR_DATA:    readdata_d = empty ? '0 : head;
        ADDR_STATUS:  readdata_d = status_word;
        ADDR_CONTROL: readdata_d = ctrl_word;
        ADDR_RSVD:    readdata_d = '0;
        default:      readdata_d = '0;
      endcase
    end
    irq_d = irq_en_q & (fifo_count != '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      arm_ack_q   <= 1'b0;
      readdata_q  <= '0;
      irq_q       <= 1'b0;
      irq_en_q    <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      arm_ack_q   <= arm_ack_d;
      readdata_q  <= readdata_d;
      irq_q       <= irq_d;
      irq_en_q    <= irq_en_d;
      underflow_q <= underflow_d;
    end
  end

  assign arm_ack  = arm_ack_q;
  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule
